// File: rtl/pipelined_control.sv
// LEGv8 control path: decodes IF/ID into a control bundle, carries it through
// ID/EX, EX/MEM and MEM/WB, and handles load-use stalls, flush, freeze and illegal-opcode accounting.
module pipelined_control #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned ZERO_REG  = 31,
  parameter int unsigned LINK_REG  = 30,
  parameter int unsigned HAZARD_EN = 1,
  parameter int unsigned ILL_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [31:0]          id_instr,
  input  logic                 id_valid,
  input  logic                 freeze,
  input  logic                 flush,
  output logic                 stall_out,
  output logic                 id_reg2loc,
  output logic                 ex_valid,
  output logic                 ex_alu_src,
  output logic [1:0]           ex_alu_op,
  output logic [REG_AW-1:0]    ex_rd,
  output logic                 mem_valid,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 mem_branch,
  output logic                 mem_uncond,
  output logic                 mem_branchlink,
  output logic                 mem_branchreg,
  output logic                 mem_not_zero,
  output logic                 wb_valid,
  output logic                 wb_reg_write,
  output logic                 wb_mem_to_reg,
  output logic [REG_AW-1:0]    wb_rd,
  output logic                 illegal_seen,
  output logic [ILL_CNT_W-1:0] illegal_count
);

  typedef struct packed {
    logic              valid;
    logic              alu_src;
    logic [1:0]        alu_op;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              uncond;
    logic              branchlink;
    logic              branchreg;
    logic              not_zero;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } ex_t;

  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              uncond;
    logic              branchlink;
    logic              branchreg;
    logic              not_zero;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } mem_t;

  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_to_reg;
    logic [REG_AW-1:0] rd;
  } wb_t;

  ex_t  idex, dec;
  mem_t exmem, mem_next;
  wb_t  memwb;
  logic [10:0] op;
  logic [4:0]  r2;
  logic illegal, reg2loc, uses_rn, uses_r2, is_bl, hazard;
  logic unused_bits;

  assign op          = id_instr[31:21];
  assign unused_bits = ^id_instr[15:10];

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    reg2loc = 1'b0;
    uses_rn = 1'b1;
    uses_r2 = 1'b0;
    is_bl   = 1'b0;
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b11001010000: begin
        dec.reg_write = 1'b1; dec.alu_op = 2'b10; uses_r2 = 1'b1;
      end
      11'b11010011011, 11'b11010011010: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b10;
      end
      11'b11111000010: begin
        dec.alu_src = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1; dec.mem_read = 1'b1;
      end
      11'b11111000000: begin
        reg2loc = 1'b1; dec.alu_src = 1'b1; dec.mem_write = 1'b1; uses_r2 = 1'b1;
      end
      11'b11010110000: dec.branchreg = 1'b1;
      11'b1011010????: begin
        reg2loc = 1'b1; dec.branch = 1'b1; dec.alu_op = 2'b01; dec.not_zero = op[3];
        uses_rn = 1'b0; uses_r2 = 1'b1;
      end
      11'b100101?????: begin
        dec.uncond = 1'b1; dec.branchlink = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b01;
        uses_rn = 1'b0; is_bl = 1'b1;
      end
      11'b000101?????: begin
        dec.uncond = 1'b1; dec.alu_op = 2'b01; uses_rn = 1'b0;
      end
      default: begin
        illegal = 1'b1; uses_rn = 1'b0;
      end
    endcase
    dec.valid = 1'b1;
    dec.rd    = is_bl ? REG_AW'(LINK_REG) : REG_AW'(id_instr[4:0]);
  end

  assign id_reg2loc = reg2loc;
  assign r2         = reg2loc ? id_instr[4:0] : id_instr[20:16];

  assign hazard = idex.valid && idex.mem_read && (idex.rd != REG_AW'(ZERO_REG)) && id_valid &&
                  ((uses_rn && (idex.rd == REG_AW'(id_instr[9:5]))) ||
                   (uses_r2 && (idex.rd == REG_AW'(r2))));
  assign stall_out = (HAZARD_EN != 0) && hazard && !flush && !freeze;

  always_comb begin
    mem_next            = '0;
    mem_next.valid      = idex.valid;
    mem_next.mem_read   = idex.mem_read;
    mem_next.mem_write  = idex.mem_write;
    mem_next.branch     = idex.branch;
    mem_next.uncond     = idex.uncond;
    mem_next.branchlink = idex.branchlink;
    mem_next.branchreg  = idex.branchreg;
    mem_next.not_zero   = idex.not_zero;
    mem_next.reg_write  = idex.reg_write;
    mem_next.mem_to_reg = idex.mem_to_reg;
    mem_next.rd         = idex.rd;
  end

  // MEM/WB advances on flush too, so the resolving branch (and BL's link write) retires.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idex          <= '0;
      exmem         <= '0;
      memwb         <= '0;
      illegal_seen  <= 1'b0;
      illegal_count <= '0;
    end else if (!freeze) begin
      memwb <= '{valid: exmem.valid, reg_write: exmem.reg_write,
                 mem_to_reg: exmem.mem_to_reg, rd: exmem.rd};
      if (flush) begin
        idex  <= '0;
        exmem <= '0;
      end else begin
        exmem <= mem_next;
        if (stall_out || !id_valid) begin
          idex <= '0;
        end else begin
          idex <= dec;
          if (illegal) begin
            illegal_seen <= 1'b1;
            if (illegal_count != '1) illegal_count <= illegal_count + ILL_CNT_W'(1);
          end
        end
      end
    end
  end

  assign ex_valid       = idex.valid;
  assign ex_alu_src     = idex.alu_src;
  assign ex_alu_op      = idex.alu_op;
  assign ex_rd          = idex.rd;
  assign mem_valid      = exmem.valid;
  assign mem_read       = exmem.mem_read;
  assign mem_write      = exmem.mem_write;
  assign mem_branch     = exmem.branch;
  assign mem_uncond     = exmem.uncond;
  assign mem_branchlink = exmem.branchlink;
  assign mem_branchreg  = exmem.branchreg;
  assign mem_not_zero   = exmem.not_zero;
  assign wb_valid       = memwb.valid;
  assign wb_reg_write   = memwb.reg_write;
  assign wb_mem_to_reg  = memwb.mem_to_reg;
  assign wb_rd          = memwb.rd;

endmodule

// File: tb/tb_pipelined_control.sv
// Bench for pipelined_control: directed scenarios plus random instruction streams
// compared against an instruction-level reference model of the three stage registers.
module tb_pipelined_control;

  logic clock = 1'b0;
  logic reset_n;
  logic [31:0] id_instr;
  logic id_valid, freeze, flush;

  logic stall_out, id_reg2loc, ex_valid, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic [4:0] ex_rd, wb_rd;
  logic mem_valid, mem_read, mem_write, mem_branch, mem_uncond, mem_branchlink, mem_branchreg, mem_not_zero;
  logic wb_valid, wb_reg_write, wb_mem_to_reg, illegal_seen;
  logic [7:0] illegal_count;

  logic n_stall, n_r2l, n_exv, n_exs;
  logic [1:0] n_exop;
  logic [4:0] n_exrd, n_wbrd;
  logic n_mv, n_mr, n_mw, n_mb, n_mu, n_mbl, n_mbr, n_mnz, n_wv, n_wrw, n_wm2r, n_ills;
  logic [7:0] n_illc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipelined_control dut (
    .clock(clock), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .freeze(freeze), .flush(flush), .stall_out(stall_out), .id_reg2loc(id_reg2loc),
    .ex_valid(ex_valid), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write), .mem_branch(mem_branch),
    .mem_uncond(mem_uncond), .mem_branchlink(mem_branchlink), .mem_branchreg(mem_branchreg),
    .mem_not_zero(mem_not_zero), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .illegal_seen(illegal_seen),
    .illegal_count(illegal_count)
  );

  pipelined_control #(.HAZARD_EN(0)) dut_nohaz (
    .clock(clock), .reset_n(reset_n), .id_instr(id_instr), .id_valid(id_valid),
    .freeze(freeze), .flush(flush), .stall_out(n_stall), .id_reg2loc(n_r2l),
    .ex_valid(n_exv), .ex_alu_src(n_exs), .ex_alu_op(n_exop), .ex_rd(n_exrd),
    .mem_valid(n_mv), .mem_read(n_mr), .mem_write(n_mw), .mem_branch(n_mb),
    .mem_uncond(n_mu), .mem_branchlink(n_mbl), .mem_branchreg(n_mbr),
    .mem_not_zero(n_mnz), .wb_valid(n_wv), .wb_reg_write(n_wrw),
    .wb_mem_to_reg(n_wm2r), .wb_rd(n_wbrd), .illegal_seen(n_ills),
    .illegal_count(n_illc)
  );

  logic [33:0] obs;
  assign obs = {ex_valid, ex_alu_src, ex_alu_op, ex_rd,
                mem_valid, mem_read, mem_write, mem_branch, mem_uncond, mem_branchlink, mem_branchreg, mem_not_zero,
                wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, illegal_seen, illegal_count};

  typedef struct packed {
    bit valid, alu_src;
    bit [1:0] alu_op;
    bit mrd, mwr, br, unc, bl, breg, nz, rw, m2r, r2l, ill, urn, ur2;
    bit [4:0] rd;
  } mi_t;

  mi_t m_ex, m_mem, m_wb;
  int  m_cnt;
  bit  m_seen;

  function automatic mi_t decode(input logic [31:0] ins);
    mi_t m;
    logic [10:0] op;
    bit rtype, shift, ldur, stur, br, cbz, cbnz, bl, b;
    op    = ins[31:21];
    rtype = op inside {11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000, 11'b11001010000};
    shift = op inside {11'b11010011011, 11'b11010011010};
    ldur  = (op == 11'b11111000010);
    stur  = (op == 11'b11111000000);
    br    = (op == 11'b11010110000);
    cbz   = (op[10:3] == 8'b10110100);
    cbnz  = (op[10:3] == 8'b10110101);
    bl    = (op[10:5] == 6'b100101);
    b     = (op[10:5] == 6'b000101);
    m = '0;
    m.valid   = 1'b1;
    m.ill     = !(rtype | shift | ldur | stur | br | cbz | cbnz | bl | b);
    m.rw      = rtype | shift | ldur | bl;
    m.alu_src = shift | ldur | stur;
    m.alu_op  = (rtype | shift) ? 2'b10 : ((cbz | cbnz | bl | b) ? 2'b01 : 2'b00);
    m.mrd     = ldur;
    m.mwr     = stur;
    m.m2r     = ldur;
    m.r2l     = stur | cbz | cbnz;
    m.br      = cbz | cbnz;
    m.nz      = cbnz;
    m.unc     = bl | b;
    m.bl      = bl;
    m.breg    = br;
    m.urn     = !(b | bl | cbz | cbnz | m.ill);
    m.ur2     = (!m.alu_src & (rtype | shift | cbz | cbnz)) | stur;
    m.rd      = bl ? 5'd30 : ins[4:0];
    return m;
  endfunction

  function automatic bit model_stall();
    mi_t d;
    bit [4:0] r2;
    bit h;
    d  = decode(id_instr);
    r2 = d.r2l ? id_instr[4:0] : id_instr[20:16];
    h  = m_ex.valid && m_ex.mrd && (m_ex.rd != 5'd31) && id_valid &&
         ((d.urn && m_ex.rd == id_instr[9:5]) || (d.ur2 && m_ex.rd == r2));
    return h && !flush && !freeze;
  endfunction

  function automatic logic [33:0] model_out();
    return {m_ex.valid, m_ex.alu_src, m_ex.alu_op, m_ex.rd,
            m_mem.valid, m_mem.mrd, m_mem.mwr, m_mem.br, m_mem.unc, m_mem.bl, m_mem.breg, m_mem.nz,
            m_wb.valid, m_wb.rw, m_wb.m2r, m_wb.rd, m_seen, m_cnt[7:0]};
  endfunction

  task automatic model_edge(input bit s);
    mi_t d;
    d = decode(id_instr);
    if (freeze) return;
    m_wb = m_mem;
    if (flush) begin
      m_mem = '0;
      m_ex  = '0;
    end else begin
      m_mem = m_ex;
      if (s || !id_valid) m_ex = '0;
      else begin
        m_ex = d;
        if (d.ill) begin
          m_seen = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_seen = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Called just after a rising edge: drive, check combinational outputs, clock, check registers.
  task automatic step(input logic [31:0] ins, input bit v, input bit fr, input bit fl);
    bit s;
    id_instr = ins; id_valid = v; freeze = fr; flush = fl;
    #1;
    s = model_stall();
    chk("stall", {63'd0, stall_out}, {63'd0, s});
    chk("stall_nohaz", {63'd0, n_stall}, 64'd0);
    chk("reg2loc", {63'd0, id_reg2loc}, {63'd0, decode(ins).r2l});
    @(posedge clock);
    model_edge(s);
    #1;
    chk("pipe", {30'd0, obs}, {30'd0, model_out()});
  endtask

  function automatic logic [4:0] pick_reg();
    return ($urandom_range(0, 8) == 8) ? 5'd31 : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    int k;
    a = pick_reg(); b = pick_reg(); c = pick_reg();
    k = $urandom_range(0, 12);
    case (k)
      0:  return {11'b10001011000, c, 6'd0, b, a};
      1:  return {11'b11001011000, c, 6'd0, b, a};
      2:  return {11'b10001010000, c, 6'd0, b, a};
      3:  return {11'b10101010000, c, 6'd0, b, a};
      4:  return {11'b11001010000, c, 6'd0, b, a};
      5:  return {10'b1101001101, 1'($urandom), 5'd0, 6'd3, b, a};
      6, 12: return {11'b11111000010, 9'd8, 2'b00, b, a};
      7:  return {11'b11111000000, 9'd8, 2'b00, b, a};
      8:  return {11'b11010110000, 5'b11111, 6'd0, b, 5'd0};
      9:  return {7'b1011010, 1'($urandom), 19'($urandom), a};
      10: return {1'($urandom), 5'b00101, 26'($urandom)};
      default: return $urandom();
    endcase
  endfunction

  localparam logic [31:0] ADD_1  = 32'h8B030041;
  localparam logic [31:0] LDUR_5 = 32'hF84000C5;
  localparam logic [31:0] ADD_75 = 32'h8B0000A7;
  localparam logic [31:0] LDUR_Z = 32'hF84000DF;
  localparam logic [31:0] ADD_7Z = 32'h8B0003E7;
  localparam logic [31:0] CBNZ_1 = 32'hB5000001;
  localparam logic [31:0] BL_5   = 32'h94000005;

  initial begin
    logic [31:0] ins;
    bit hold;
    reset_n = 1'b0; id_instr = '0; id_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
    model_reset();
    @(posedge clock); #1;
    chk("reset_state", {30'd0, obs}, 64'd0);
    reset_n = 1'b1;

    step(ADD_1, 1, 0, 0);
    chk("add_ex_valid", {63'd0, ex_valid}, 64'd1);
    chk("add_ex_alu_op", {62'd0, ex_alu_op}, 64'd2);
    chk("add_ex_rd", {59'd0, ex_rd}, 64'd1);
    step(32'd0, 0, 0, 0);
    step(32'd0, 0, 0, 0);
    chk("add_wb_reg_write", {63'd0, wb_reg_write}, 64'd1);
    chk("add_wb_rd", {59'd0, wb_rd}, 64'd1);

    step(LDUR_5, 1, 0, 0);
    id_instr = ADD_75; id_valid = 1'b1; #1;
    chk("loaduse_stall", {63'd0, stall_out}, 64'd1);
    step(ADD_75, 1, 0, 0);
    chk("loaduse_bubble", {63'd0, ex_valid}, 64'd0);
    step(ADD_75, 1, 0, 0);
    chk("loaduse_add_ex", {58'd0, ex_valid, ex_rd}, {58'd0, 1'b1, 5'd7});

    step(LDUR_Z, 1, 0, 0);
    step(ADD_7Z, 1, 0, 0);
    chk("zero_reg_no_bubble", {63'd0, ex_valid}, 64'd1);

    step(BL_5, 1, 0, 0);
    chk("bl_link_rd", {59'd0, ex_rd}, 64'd30);

    step(CBNZ_1, 1, 0, 0);
    step(LDUR_5, 1, 0, 0);
    step(ADD_75, 1, 0, 1);
    chk("flush_mem_bubble", {63'd0, mem_valid}, 64'd0);
    chk("flush_wb_cbnz", {62'd0, wb_valid, wb_reg_write}, {62'd0, 2'b10});
    chk("flush_ex_bubble", {63'd0, ex_valid}, 64'd0);

    for (int i = 0; i < 300; i++) step(32'd0, 1, 0, 0);
    chk("ill_seen", {63'd0, illegal_seen}, 64'd1);
    chk("ill_count_sat", {56'd0, illegal_count}, 64'd255);
    for (int i = 0; i < 3; i++) step(32'd0, 1, 1, (i == 1));
    chk("freeze_count", {56'd0, illegal_count}, 64'd255);

    reset_n = 1'b0;
    model_reset();
    step(32'd0, 0, 0, 0);
    reset_n = 1'b1;

    hold = 1'b0;
    ins  = rand_instr();
    for (int i = 0; i < 400; i++) begin
      bit v, fr, fl;
      if (!hold) ins = rand_instr();
      v  = ($urandom_range(0, 99) < 88);
      fr = ($urandom_range(0, 99) < 10);
      fl = ($urandom_range(0, 99) < 7);
      hold = fr;
      id_instr = ins; id_valid = v; freeze = fr; flush = fl;
      #0;
      if (model_stall()) hold = 1'b1;
      step(ins, v, fr, fl);
    end

    step(LDUR_5, 1, 0, 0);
    step(32'd0, 1, 0, 0);
    reset_n = 1'b0;
    #1;
    chk("async_reset", {30'd0, obs}, 64'd0);
    model_reset();
    @(posedge clock); #1;
    reset_n = 1'b1;
    step(ADD_1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
